// File: rtl/fft_butterfly_stage_pkg.sv
// Shared constants and helpers for the radix-2 butterfly stage.
// Q1.(WL-1) limits and the saturating clamp live here.
package fft_butterfly_stage_pkg;

  localparam int WL_DEF = 16;

  localparam logic [WL_DEF-1:0] MAX_POS =
    {1'b0, {(WL_DEF-1){1'b1}}};
  localparam logic [WL_DEF-1:0] MAX_NEG =
    {1'b1, {(WL_DEF-1){1'b0}}};

  // Clamp a WL+1 bit sum back into WL bits.
  function automatic logic [WL_DEF-1:0] sat_wl(
    input logic [WL_DEF:0] v
  );
    if (v[WL_DEF] != v[WL_DEF-1])
      return v[WL_DEF] ? MAX_NEG : MAX_POS;
    return v[WL_DEF-1:0];
  endfunction

endpackage

// File: rtl/fft_butterfly_stage_if.sv
// Butterfly data bus: operands/product in, X/Y out.
// The stage is streaming, so there is no ready.
interface fft_butterfly_stage_if #(
  parameter int WL = 16
);

  logic          in_valid;
  logic [WL-1:0] a_r;
  logic [WL-1:0] a_i;
  logic [WL-1:0] p_r;
  logic [WL-1:0] p_i;
  logic          ovf_clr;
  logic          out_valid;
  logic [WL-1:0] x_r;
  logic [WL-1:0] x_i;
  logic [WL-1:0] y_r;
  logic [WL-1:0] y_i;
  logic          out_last;
  logic          ovf_sticky;

  modport master (
    output in_valid, a_r, a_i, p_r, p_i, ovf_clr,
    input  out_valid, x_r, x_i, y_r, y_i,
    input  out_last, ovf_sticky
  );

  modport slave (
    input  in_valid, a_r, a_i, p_r, p_i, ovf_clr,
    output out_valid, x_r, x_i, y_r, y_i,
    output out_last, ovf_sticky
  );

endinterface

// File: rtl/fft_butterfly_stage_pipe_delay.sv
// Plain register shift line of DEPTH stages.
// Aligns A and its valid with the multiplier pipeline.
module pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  // Shift one stage per clock; reset empties the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_butterfly_stage.sv
// Radix-2 DIT butterfly: X = A + P, Y = A - P.
// Scales or saturates, tracks frame position.
module fft_butterfly_stage
  import fft_butterfly_stage_pkg::*;
#(
  parameter int WL       = WL_DEF,
  parameter int MULT_LAT = 2,
  parameter int N_POINTS = 8,
  parameter int SCALE    = 1
) (
  input logic clk,
  input logic rst,
  fft_butterfly_stage_if.slave bus
);

  localparam int HALF = N_POINTS / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  localparam logic [WL-1:0] POS =
    {1'b0, {(WL-1){1'b1}}};
  localparam logic [WL-1:0] NEG =
    {1'b1, {(WL-1){1'b0}}};

  // Halve (floor) or clamp a WL+1 bit result.
  function automatic logic [WL-1:0] fit(
    input logic [WL:0] v
  );
    if (SCALE != 0)
      return v[WL:1];
    if (v[WL] != v[WL-1])
      return v[WL] ? NEG : POS;
    return v[WL-1:0];
  endfunction

  function automatic logic clip(
    input logic [WL:0] v
  );
    return (SCALE == 0) && (v[WL] != v[WL-1]);
  endfunction

  logic [2*WL-1:0] a_q;
  logic            v_q;
  logic [WL-1:0]   ad_r;
  logic [WL-1:0]   ad_i;

  pipe_delay #(
    .W     (2*WL),
    .DEPTH (MULT_LAT)
  ) u_a_dly (
    .clk (clk),
    .rst (rst),
    .d   ({bus.a_r, bus.a_i}),
    .q   (a_q)
  );

  pipe_delay #(
    .W     (1),
    .DEPTH (MULT_LAT)
  ) u_v_dly (
    .clk (clk),
    .rst (rst),
    .d   (bus.in_valid),
    .q   (v_q)
  );

  assign {ad_r, ad_i} = a_q;

  logic [WL:0] s_r;
  logic [WL:0] s_i;
  logic [WL:0] d_r;
  logic [WL:0] d_i;
  logic        any_clip;

  // Sign-extended add/sub, one guard bit.
  always_comb begin
    s_r = {ad_r[WL-1], ad_r} + {bus.p_r[WL-1], bus.p_r};
    s_i = {ad_i[WL-1], ad_i} + {bus.p_i[WL-1], bus.p_i};
    d_r = {ad_r[WL-1], ad_r} - {bus.p_r[WL-1], bus.p_r};
    d_i = {ad_i[WL-1], ad_i} - {bus.p_i[WL-1], bus.p_i};
    any_clip = clip(s_r) | clip(s_i) |
               clip(d_r) | clip(d_i);
  end

  logic [WL-1:0] x_r_q;
  logic [WL-1:0] x_i_q;
  logic [WL-1:0] y_r_q;
  logic [WL-1:0] y_i_q;
  logic          ov_q;
  logic          last_q;
  logic          ovf_q;
  logic [CW-1:0] cnt;

  // Output register, frame counter and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r_q  <= '0;
      x_i_q  <= '0;
      y_r_q  <= '0;
      y_i_q  <= '0;
      ov_q   <= 1'b0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      ov_q   <= v_q;
      last_q <= v_q && (cnt == LAST);
      if (v_q) begin
        x_r_q <= fit(s_r);
        x_i_q <= fit(s_i);
        y_r_q <= fit(d_r);
        y_i_q <= fit(d_i);
        cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      if (v_q && any_clip)
        ovf_q <= 1'b1;
      else if (bus.ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  assign bus.out_valid  = ov_q;
  assign bus.out_last   = last_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.x_r        = x_r_q;
  assign bus.x_i        = x_i_q;
  assign bus.y_r        = y_r_q;
  assign bus.y_i        = y_i_q;

endmodule
